// File: rtl/ds_pkg.sv
// Shared definitions for the DS-format load/store controller.
package ds_pkg;
  localparam logic [5:0] PO_LD    = 6'd58;
  localparam logic [5:0] PO_STD   = 6'd62;
  localparam logic [1:0] XO_BASE  = 2'd0;
  localparam logic [1:0] XO_UPD   = 2'd1;
  localparam int         DS_EXT_W = 64;

  typedef enum logic [2:0] {IDLE, ADDR, MEM, WB_RT, WB_RA, DONE} state_t;

  function automatic logic [5:0] f_po(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_ra(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [13:0] f_ds(input logic [31:0] i);
    return i[15:2];
  endfunction

  function automatic logic [1:0] f_xo(input logic [31:0] i);
    return i[1:0];
  endfunction

  // DS is a word offset: append 2'b00 and sign-extend to the widest XLEN.
  function automatic logic [DS_EXT_W-1:0] sext_ds(input logic [13:0] ds);
    return {{(DS_EXT_W-16){ds[13]}}, ds, 2'b00};
  endfunction
endpackage

// File: rtl/ds_decode.sv
// Combinational classifier for LD/LDU/STD/STDU.
module ds_decode
  import ds_pkg::*;
(
  input  logic [5:0] po,
  input  logic [1:0] xo,
  input  logic [4:0] rt,
  input  logic [4:0] ra,
  output logic       is_load,
  output logic       is_update,
  output logic       illegal
);
  logic known;

  // Update forms need a real base register; LDU cannot target its own base.
  always_comb begin
    is_load   = (po == PO_LD);
    is_update = (xo == XO_UPD);
    known     = (po == PO_LD || po == PO_STD) && (xo == XO_BASE || xo == XO_UPD);
    illegal   = !known || (is_update && ra == 5'd0) ||
                (is_load && is_update && ra == rt);
  end
endmodule

// File: rtl/ds_ldst_controller.sv
// Multi-cycle sequencer for DS-format loads/stores: decode, EA, one memory
// transaction with timeout, then writeback of RT and/or RA.
module ds_ldst_controller
  import ds_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [4:0]      rf_ra_addr,
  output logic [4:0]      rf_rt_addr,
  input  logic [XLEN-1:0] rf_ra_data,
  input  logic [XLEN-1:0] rf_rt_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            err_illegal,
  output logic            err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state, state_nx;
  logic [4:0]          rt_q, ra_q;
  logic [13:0]         ds_q;
  logic                load_q, upd_q;
  logic [XLEN-1:0]     ea_q, wdata_q, rdata_q;
  logic [CW-1:0]       cnt_q;
  logic                err_ill_q, err_to_q;
  logic                dec_load, dec_upd, dec_ill;
  logic                mem_to;
  logic [DS_EXT_W-1:0] off_ext;
  logic [XLEN-1:0]     base, ea_nx;

  ds_decode u_dec (
    .po        (f_po(instr)),
    .xo        (f_xo(instr)),
    .rt        (f_rt(instr)),
    .ra        (f_ra(instr)),
    .is_load   (dec_load),
    .is_update (dec_upd),
    .illegal   (dec_ill)
  );

  // RA=0 means literal zero base, not GPR0; sum wraps modulo 2^XLEN.
  assign off_ext = sext_ds(ds_q);
  assign base    = (ra_q == 5'd0) ? '0 : rf_ra_data;
  assign ea_nx   = base + off_ext[XLEN-1:0];

  assign busy        = (state != IDLE);
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;
  assign mem_addr    = (state == MEM) ? ea_q    : '0;
  assign mem_wdata   = (state == MEM) ? wdata_q : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-state outputs; an ack on the last allowed cycle wins.
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    rf_ra_addr  = '0;
    rf_rt_addr  = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    mem_to      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && !dec_ill) state_nx = ADDR;
      end
      ADDR: begin
        rf_ra_addr = ra_q;
        rf_rt_addr = rt_q;
        state_nx   = MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = !load_q;
        if (mem_ack)
          state_nx = load_q ? WB_RT : (upd_q ? WB_RA : DONE);
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_to   = 1'b1;
          state_nx = IDLE;
        end
      end
      WB_RT: begin
        rf_we    = 1'b1;
        rf_wa    = rt_q;
        rf_wd    = rdata_q;
        state_nx = upd_q ? WB_RA : DONE;
      end
      WB_RA: begin
        rf_we    = 1'b1;
        rf_wa    = ra_q;
        rf_wd    = ea_q;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latched fields, EA/store data, wait counter and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_q      <= '0;
      ra_q      <= '0;
      ds_q      <= '0;
      load_q    <= 1'b0;
      upd_q     <= 1'b0;
      ea_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      err_ill_q <= (state == IDLE) && instr_valid && dec_ill;
      err_to_q  <= mem_to;
      if (state == IDLE && instr_valid) begin
        rt_q   <= f_rt(instr);
        ra_q   <= f_ra(instr);
        ds_q   <= f_ds(instr);
        load_q <= dec_load;
        upd_q  <= dec_upd;
      end
      if (state == ADDR) begin
        ea_q    <= ea_nx;
        wdata_q <= rf_rt_data;
        cnt_q   <= '0;
      end
      if (state == MEM && !mem_ack) cnt_q <= cnt_q + 1'b1;
      if (state == MEM && mem_ack && load_q) rdata_q <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_ds_ldst_controller.sv
// Self-checking bench: directed vector table, reset/timeout sequences, and
// randomized instructions against a transaction-level reference model.
module tb_ds_ldst_controller;
  localparam int XLEN    = 64;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic [31:0]     instr = '0;
  logic            instr_ready;
  logic [4:0]      rf_ra_addr, rf_rt_addr, rf_wa;
  logic [XLEN-1:0] rf_ra_data, rf_rt_data, rf_wd;
  logic            rf_we, mem_req, mem_we, mem_ack = 1'b0;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic            busy, done, err_illegal, err_timeout;

  logic [63:0] gpr [32];
  int tests = 0, fails = 0;

  assign rf_ra_data = gpr[rf_ra_addr];
  assign rf_rt_data = gpr[rf_rt_addr];

  always #5 clk = ~clk;

  ds_ldst_controller #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_ra_addr(rf_ra_addr), .rf_rt_addr(rf_rt_addr),
    .rf_ra_data(rf_ra_data), .rf_rt_data(rf_rt_data), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  // Observed (or expected) outcome of one instruction; cycles count from the acceptance edge.
  typedef struct {
    int              ill_cyc, to_cyc, done_cyc, req_first, req_cycles, nwr, wc0, wc1;
    logic [63:0]     addr, wdata;
    logic            we;
    bit              unstable;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd;
  } obs_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic [4:0]  ra_r;
    logic [63:0] ra_v;
    logic [4:0]  rt_r;
    logic [63:0] rt_v;
    int          wt;
    logic [63:0] rd;
    bit          e_ill, e_to;
    logic [63:0] e_addr;
    bit          e_we;
    int          e_done;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decode rules, EA arithmetic and the latency rules as plain arithmetic.
  function automatic obs_t model(input logic [31:0] ins, input int wt, input logic [63:0] rd);
    obs_t e = '{default:0};
    int po = int'(ins[31:26]);
    int rt = int'(ins[25:21]);
    int ra = int'(ins[20:16]);
    int xo = int'(ins[1:0]);
    longint off = longint'($signed(ins[15:2])) * 4;
    bit ld  = (po == 58);
    bit upd = (xo == 1);
    bit legal = (po == 58 || po == 62) && xo <= 1 && !(upd && ra == 0) && !(ld && upd && ra == rt);
    logic [63:0] ea;
    int cyc;
    if (!legal) begin e.ill_cyc = 1; return e; end
    ea = ((ra == 0) ? 64'd0 : gpr[ra]) + 64'(off);
    e.req_first = 2; e.addr = ea; e.we = !ld; e.wdata = gpr[rt];
    if (wt < 0 || wt >= TIMEOUT) begin
      e.req_cycles = TIMEOUT; e.to_cyc = 2 + TIMEOUT; return e;
    end
    e.req_cycles = wt + 1;
    cyc = 3 + wt;
    if (ld) begin e.wa[0] = 5'(rt); e.wd[0] = rd; e.wc0 = cyc; e.nwr = 1; cyc++; end
    if (upd) begin
      if (e.nwr == 0) begin e.wa[0] = 5'(ra); e.wd[0] = ea; e.wc0 = cyc; end
      else            begin e.wa[1] = 5'(ra); e.wd[1] = ea; e.wc1 = cyc; end
      e.nwr++; cyc++;
    end
    e.done_cyc = cyc;
    return e;
  endfunction

  task automatic apply_writes(input obs_t e);
    if (e.nwr > 0) gpr[e.wa[0]] = e.wd[0];
    if (e.nwr > 1) gpr[e.wa[1]] = e.wd[1];
  endtask

  // Offer one instruction and act as memory (ack after wt wait cycles, -1 = never).
  task automatic run(input logic [31:0] ins, input int wt, input logic [63:0] rd,
                     input bit noise, output obs_t o);
    o = '{default:0};
    @(negedge clk);
    chk("instr_ready", 64'(instr_ready), 64'd1);
    instr = ins; instr_valid = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_req) begin
        if (o.req_cycles == 0) begin
          o.req_first = k; o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata)
          o.unstable = 1'b1;
        if (o.req_cycles == wt) begin mem_ack = 1'b1; mem_rdata = rd; end
        o.req_cycles++;
      end else if (noise) mem_ack = ($urandom % 4 == 0);
      if (rf_we) begin
        if (o.nwr == 0)      begin o.wa[0] = rf_wa; o.wd[0] = rf_wd; o.wc0 = k; end
        else if (o.nwr == 1) begin o.wa[1] = rf_wa; o.wd[1] = rf_wd; o.wc1 = k; end
        o.nwr++;
      end
      if (done && o.done_cyc == 0)        o.done_cyc = k;
      if (err_illegal && o.ill_cyc == 0)  o.ill_cyc = k;
      if (err_timeout && o.to_cyc == 0)   o.to_cyc = k;
      if (done || err_illegal || err_timeout) break;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("post_idle", 64'({done, busy, err_illegal, err_timeout, mem_req, rf_we}), 64'd0);
  endtask

  task automatic cmp(input string t, input obs_t o, input obs_t e);
    chk({t, "_ill_cyc"}, 64'(o.ill_cyc), 64'(e.ill_cyc));
    chk({t, "_to_cyc"}, 64'(o.to_cyc), 64'(e.to_cyc));
    chk({t, "_done_cyc"}, 64'(o.done_cyc), 64'(e.done_cyc));
    chk({t, "_req_cycles"}, 64'(o.req_cycles), 64'(e.req_cycles));
    chk({t, "_nwr"}, 64'(o.nwr), 64'(e.nwr));
    if (e.req_cycles > 0) begin
      chk({t, "_req_first"}, 64'(o.req_first), 64'(e.req_first));
      chk({t, "_addr"}, o.addr, e.addr);
      chk({t, "_we"}, 64'(o.we), 64'(e.we));
      chk({t, "_stable"}, 64'(o.unstable), 64'd0);
      if (e.we) chk({t, "_wdata"}, o.wdata, e.wdata);
    end
    if (e.nwr > 0 && o.nwr > 0) begin
      chk({t, "_wa0"}, 64'(o.wa[0]), 64'(e.wa[0]));
      chk({t, "_wd0"}, o.wd[0], e.wd[0]);
      chk({t, "_wc0"}, 64'(o.wc0), 64'(e.wc0));
    end
    if (e.nwr > 1 && o.nwr > 1) begin
      chk({t, "_wa1"}, 64'(o.wa[1]), 64'(e.wa[1]));
      chk({t, "_wd1"}, o.wd[1], e.wd[1]);
      chk({t, "_wc1"}, 64'(o.wc1), 64'(e.wc1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, e;
    int   seen;
    for (int i = 0; i < 32; i++) gpr[i] = '0;

    tbl[0]  = '{"ld",        32'hE8430008, 5'd3,  64'h1000, 5'd2, 64'h0,  0,  64'hDEADBEEF, 0, 0, 64'h1008, 1'b0, 4};
    tbl[1]  = '{"std",       32'hF9230010, 5'd3,  64'h1000, 5'd9, 64'h55, 0,  64'h0,        0, 0, 64'h1010, 1'b1, 3};
    tbl[2]  = '{"ldu_wait3", 32'hE8EAFFF9, 5'd10, 64'h2000, 5'd7, 64'h0,  3,  64'hA5A5,     0, 0, 64'h1FF8, 1'b0, 8};
    tbl[3]  = '{"ld_ra0",    32'hE8800020, 5'd0,  64'hFFFF, 5'd4, 64'h0,  0,  64'h77,       0, 0, 64'h20,   1'b0, 4};
    tbl[4]  = '{"stdu_ra0",  32'hF9200011, 5'd0,  64'h0,    5'd9, 64'h55, 0,  64'h0,        1, 0, 64'h0,    1'b0, 0};
    tbl[5]  = '{"ldu_rart",  32'hE8630009, 5'd3,  64'h1000, 5'd3, 64'h1000, 0, 64'h0,       1, 0, 64'h0,    1'b0, 0};
    tbl[6]  = '{"po31",      32'h7C000000, 5'd0,  64'h0,    5'd0, 64'h0,  0,  64'h0,        1, 0, 64'h0,    1'b0, 0};
    tbl[7]  = '{"ld_xo2",    32'hE8430002, 5'd3,  64'h1000, 5'd2, 64'h0,  0,  64'h0,        1, 0, 64'h0,    1'b0, 0};
    tbl[8]  = '{"stdu",      32'hF9230011, 5'd3,  64'h1000, 5'd9, 64'h55, 0,  64'h0,        0, 0, 64'h1010, 1'b1, 4};
    tbl[9]  = '{"ea_wrap",   32'hE8430010, 5'd3,  64'hFFFF_FFFF_FFFF_FFF8, 5'd2, 64'h0, 0, 64'h1, 0, 0, 64'h8, 1'b0, 4};
    tbl[10] = '{"ack_last",  32'hE8430008, 5'd3,  64'h1000, 5'd2, 64'h0,  TIMEOUT-1, 64'hBEEF, 0, 0, 64'h1008, 1'b0, 4+TIMEOUT-1};
    tbl[11] = '{"timeout",   32'hE8430008, 5'd3,  64'h1000, 5'd2, 64'h0,  -1, 64'h0,        0, 1, 64'h1008, 1'b0, 0};

    // Reset values while rst_n is held low.
    #12;
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_outs", 64'({busy, done, err_illegal, err_timeout, mem_req, mem_we, rf_we}), 64'd0);
    chk("rst_buses", 64'(mem_addr | mem_wdata | rf_wd | 64'({rf_wa, rf_ra_addr, rf_rt_addr})), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    foreach (tbl[i]) begin
      gpr[tbl[i].ra_r] = tbl[i].ra_v;
      gpr[tbl[i].rt_r] = tbl[i].rt_v;
      e = model(tbl[i].ins, tbl[i].wt, tbl[i].rd);
      run(tbl[i].ins, tbl[i].wt, tbl[i].rd, 1'b0, o);
      chk({tbl[i].nm, "_ill"}, 64'(o.ill_cyc != 0), 64'(tbl[i].e_ill));
      chk({tbl[i].nm, "_to"}, 64'(o.to_cyc != 0), 64'(tbl[i].e_to));
      chk({tbl[i].nm, "_done"}, 64'(o.done_cyc), 64'(tbl[i].e_done));
      if (!tbl[i].e_ill) begin
        chk({tbl[i].nm, "_maddr"}, o.addr, tbl[i].e_addr);
        chk({tbl[i].nm, "_mwe"}, 64'(o.we), 64'(tbl[i].e_we));
      end else
        chk({tbl[i].nm, "_noside"}, 64'(o.req_cycles + o.nwr), 64'd0);
      cmp(tbl[i].nm, o, e);
      apply_writes(e);
    end

    // Ack one cycle past the limit must lose to the timeout.
    e = model(32'hE8430008, TIMEOUT, 64'h1);
    run(32'hE8430008, TIMEOUT, 64'h1, 1'b0, o);
    cmp("ack_late", o, e);

    // Reset asserted mid-MEM: outputs drop at once and no writeback follows.
    @(negedge clk);
    instr = 32'hE8430008; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 64'({busy, done, err_illegal, err_timeout, mem_req, mem_we, rf_we}), 64'd0);
    chk("midrst_ready", 64'(instr_ready), 64'd1);
    chk("midrst_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rf_we || mem_req || done || busy) seen++;
    end
    chk("midrst_quiet", 64'(seen), 64'd0);

    // Randomized instructions against the reference model.
    for (int i = 0; i < 32; i++) gpr[i] = {$urandom, $urandom};
    for (int n = 0; n < 150; n++) begin
      logic [5:0]  po;
      logic [4:0]  rt, ra;
      logic [13:0] ds;
      logic [1:0]  xo;
      logic [31:0] ins;
      logic [63:0] rd;
      int          sel, wt;
      sel = int'($urandom % 8);
      po  = (sel < 3) ? 6'd58 : (sel < 6) ? 6'd62 : 6'($urandom);
      xo  = ($urandom % 8 == 0) ? 2'($urandom) : 2'($urandom % 2);
      rt  = 5'($urandom);
      ra  = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      ds  = 14'($urandom);
      ins = {po, rt, ra, ds, xo};
      rd  = {$urandom, $urandom};
      sel = int'($urandom % 20);
      wt  = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      e = model(ins, wt, rd);
      run(ins, wt, rd, 1'b1, o);
      cmp($sformatf("rnd%0d", n), o, e);
      apply_writes(e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ds_ldst_controller.md
Name: ds_ldst_controller

Overview:
- Multi-cycle sequencer for uPower DS-format load/store instructions: LD, LDU, STD, STDU.
- Accepts one 32-bit instruction via valid/ready and reads GPRs through the register-file read ports.
- Computes the effective address, runs one data-memory transaction with a req/ack handshake, then performs writeback to RT and/or RA.
- Sits between the fetch/decode stage and the DS_Format register-file/memory datapath.

Parameters:
- XLEN, 64, width of GPRs, addresses and memory data.
- TIMEOUT, 15, maximum cycles mem_req may stay unacknowledged before abort.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word; PO=instr[31:26], RT=[25:21], RA=[20:16], DS=[15:2], XO=[1:0]
- instr_ready  out  1  controller can accept an instruction
- rf_ra_addr  out  5  GPR read address A (RA)
- rf_rt_addr  out  5  GPR read address B (RT, store source)
- rf_ra_data  in  XLEN  combinational read data for rf_ra_addr
- rf_rt_data  in  XLEN  combinational read data for rf_rt_addr
- rf_we  out  1  GPR write enable
- rf_wa  out  5  GPR write address
- rf_wd  out  XLEN  GPR write data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=store, 0=load
- mem_addr  out  XLEN  effective address
- mem_wdata  out  XLEN  store data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  XLEN  load data, valid with mem_ack
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an instruction retires
- err_illegal  out  1  one-cycle pulse: instruction rejected
- err_timeout  out  1  one-cycle pulse: memory timeout abort

Behaviour:
- Reset (async, rst_n=0): state IDLE; instr_ready=1; all other outputs 0; latched fields, EA and timeout counter cleared.
- Reset mid-operation: any in-flight transaction is abandoned; mem_req drops immediately; no writeback occurs.
- Decode:
  - LD is PO=58, XO=0; LDU is PO=58, XO=1.
  - STD is PO=62, XO=0; STDU is PO=62, XO=1.
  - Any other PO/XO is illegal.
  - Also illegal: update forms with RA=0, and LDU with RA==RT.
  - Illegal instruction is consumed: err_illegal pulses the cycle after acceptance; state stays IDLE; no memory access; no GPR write.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch PO/RT/RA/DS/XO and go to ADDR.
- ADDR (1 cycle):
  - rf_ra_addr=RA, rf_rt_addr=RT.
  - EA = (RA==0 ? 0 : rf_ra_data) + sign_extend(DS||2'b00) to XLEN; arithmetic is modulo 2^XLEN (wrap, no flag).
  - Latch EA, and latch rf_rt_data as store data.
  - Next state is MEM.
- MEM:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable until ack.
  - Timeout counter starts at 0 on entry and increments each cycle without ack.
  - On mem_ack: loads latch mem_rdata. Next state is WB_RT for LD/LDU, WB_RA for STDU, DONE for STD.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, pulse err_timeout, return to IDLE, no writeback.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- WB_RT: rf_we=1, rf_wa=RT, rf_wd=load data. Next state is WB_RA for LDU, DONE for LD.
- WB_RA: rf_we=1, rf_wa=RA, rf_wd=EA. Next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency with zero-wait ack (ack in first MEM cycle), acceptance edge = cycle 0:
  - mem_req high in cycle 2.
  - STD: done in cycle 3.
  - LD and STDU: done in cycle 4.
  - LDU: done in cycle 5.
  - Each ack wait cycle adds 1.
- At most one rf write per cycle; rf_we=0 in all other states.
- mem_ack outside MEM is ignored.

Decomposition:
- Shared package ds_pkg holds:
  - PO constants PO_LD=6'd58, PO_STD=6'd62; XO constants XO_BASE=2'd0, XO_UPD=2'd1.
  - State encoding: IDLE, ADDR, MEM, WB_RT, WB_RA, DONE.
  - Field-slice helper functions and the DS sign-extension function.
- One natural sub-module: ds_decode, a combinational classifier producing is_load, is_update, illegal from PO/XO/RT/RA.

Test Plan:
- LD R2,8(R3): instr=0xE8430008, GPR3=0x1000, mem_rdata=0xDEADBEEF, zero-wait ack -> mem_addr=0x1008, mem_we=0; rf write R2=0xDEADBEEF; done in cycle 4.
- STD R9,16(R3): instr=0xF9230010, GPR3=0x1000, GPR9=0x55 -> mem_addr=0x1010, mem_we=1, mem_wdata=0x55; no rf_we; done in cycle 3.
- LDU R7,-8(R10): instr=0xE8EAFFF9, GPR10=0x2000, ack after 3 wait cycles -> mem_addr=0x1FF8; R7 written, then R10=0x1FF8 in the next cycle; done in cycle 8.
- LD R4,32(0): instr=0xE8800020, rf_ra_data=0xFFFF -> EA=0x20 (RA=0 forces base 0).
- Illegal cases: STDU with RA=0 (0xF9200011), LDU with RA==RT (0xE8630009), PO=31 -> err_illegal pulse for each; mem_req and rf_we stay 0.
- Timeout: LD with mem_ack never asserted -> mem_req high for TIMEOUT cycles, err_timeout pulse, IDLE, no rf_we. Also assert rst_n=0 mid-MEM -> all outputs return to reset values immediately.
